// File: rtl/accumulator_datapath_if.sv
// Operation handshake and result bus for accumulator_datapath.
// The master side presents operations; the slave side (the datapath) returns status and results.
interface accumulator_datapath_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NUM_REGS = 2
);
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [SEL_W-1:0] op_sel;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_data;
    logic             overflow;
    logic             done;

    modport master (
        output op_valid,
        output op_code,
        output op_sel,
        output op_data,
        input  op_ready,
        input  acc,
        input  out_data,
        input  overflow,
        input  done
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_sel,
        input  op_data,
        output op_ready,
        output acc,
        output out_data,
        output overflow,
        output done
    );
endinterface

// File: rtl/accumulator_datapath.sv
// Three-phase (IDLE/EXEC/WB) accumulator with operand registers, output register and sticky overflow.
// Build macro ACCUMULATOR_SATURATE_EN: clamp overflowing ADD/SHL to all-ones and borrowing SUB to 0.
module accumulator_datapath #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NUM_REGS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    accumulator_datapath_if.slave  bus
);
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_CLR  = 3'd6,
        OP_OUT  = 3'd7
    } op_e;

    state_e           state_q;
    op_e              op_code_q;
    logic [SEL_W-1:0] op_sel_q;
    logic [WIDTH-1:0] op_data_q;
    logic [WIDTH-1:0] res_q;
    logic             res_ovf_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q;
    logic             done_q;
    logic             ready_q;
    logic [WIDTH-1:0] regs_q [NUM_REGS];

    logic [WIDTH-1:0] operand_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] diff_c;
    logic             borrow_c;
    logic [WIDTH-1:0] res_d;
    logic             res_ovf_d;

    // Operand mux; an index beyond the register file reads as zero.
    always_comb begin
        operand_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (op_sel_q == SEL_W'(i)) begin
                operand_c = regs_q[i];
            end
        end
    end

    // Arithmetic for the captured operation, latched into res_q during EXEC.
    always_comb begin
        sum_c     = {1'b0, acc_q} + {1'b0, operand_c};
        diff_c    = acc_q - operand_c;
        borrow_c  = (operand_c > acc_q);
        res_d     = acc_q;
        res_ovf_d = 1'b0;
        case (op_code_q)
            OP_ADD: begin
                res_d     = sum_c[WIDTH-1:0];
                res_ovf_d = sum_c[WIDTH];
            end
            OP_SUB: begin
                res_d     = diff_c;
                res_ovf_d = borrow_c;
            end
            OP_SHL: begin
                res_d     = {acc_q[WIDTH-2:0], 1'b0};
                res_ovf_d = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                res_d     = {1'b0, acc_q[WIDTH-1:1]};
            end
            default: begin
                res_d     = acc_q;
            end
        endcase
`ifdef ACCUMULATOR_SATURATE_EN
        if (res_ovf_d) begin
            res_d = (op_code_q == OP_SUB) ? '0 : '1;
        end
`endif
    end

    // Control FSM and all architectural state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_code_q <= OP_NOP;
            op_sel_q  <= '0;
            op_data_q <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            acc_q     <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_code_q <= op_e'(bus.op_code);
                        op_sel_q  <= bus.op_sel;
                        op_data_q <= bus.op_data;
                        ready_q   <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q     <= res_d;
                    res_ovf_q <= res_ovf_d;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    case (op_code_q)
                        OP_LOAD: begin
                            // Out-of-range index matches no register, so the load is dropped.
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (op_sel_q == SEL_W'(i)) begin
                                    regs_q[i] <= op_data_q;
                                end
                            end
                        end
                        OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
                            acc_q <= res_q;
                            ovf_q <= ovf_q | res_ovf_q;
                        end
                        OP_CLR: begin
                            acc_q <= '0;
                            ovf_q <= 1'b0;
                        end
                        OP_OUT: begin
                            out_q <= acc_q;
                        end
                        default: begin
                            acc_q <= acc_q;
                        end
                    endcase
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready = ready_q;
    assign bus.acc      = acc_q;
    assign bus.out_data = out_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Directed bench for accumulator_datapath: vector table plus throughput, reset-abort and bad-index sequences.
module tb_accumulator_datapath;
`ifdef ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    accumulator_datapath_if #(.WIDTH(4), .NUM_REGS(2)) bus_a ();
    accumulator_datapath_if #(.WIDTH(4), .NUM_REGS(3)) bus_b ();

    accumulator_datapath #(.WIDTH(4), .NUM_REGS(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    accumulator_datapath #(.WIDTH(4), .NUM_REGS(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        logic [2:0] code;
        logic [1:0] sel;
        logic [3:0] data;
        logic [3:0] acc_w;
        logic [3:0] acc_s;
        logic       ovf;
        logic [3:0] out_w;
        logic [3:0] out_s;
    } vec_t;

    vec_t vecs [25];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int rdy(input bit b);
        return b ? int'(bus_b.op_ready) : int'(bus_a.op_ready);
    endfunction
    function automatic int dn(input bit b);
        return b ? int'(bus_b.done) : int'(bus_a.done);
    endfunction
    function automatic int acc_of(input bit b);
        return b ? int'(bus_b.acc) : int'(bus_a.acc);
    endfunction

    task automatic drive(input bit b, input logic v, input logic [2:0] code,
                         input logic [1:0] sel, input logic [3:0] data);
        if (b) begin
            bus_b.op_valid = v; bus_b.op_code = code; bus_b.op_sel = sel; bus_b.op_data = data;
        end else begin
            bus_a.op_valid = v; bus_a.op_code = code; bus_a.op_sel = sel[0]; bus_a.op_data = data;
        end
    endtask

    // Called at a falling edge; returns the number of falling edges from accept to done (-1 if none).
    task automatic run_op(input bit b, input logic [2:0] code, input logic [1:0] sel,
                          input logic [3:0] data, output int lat);
        int waited;
        waited = 0;
        while (rdy(b) == 0 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", rdy(b), 1);
        drive(b, 1'b1, code, sel, data);
        @(posedge clk);
        #1;
        drive(b, 1'b0, code, sel, data);
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (dn(b) != 0) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0]  = '{3'd1, 2'd0, 4'd7, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[1]  = '{3'd1, 2'd1, 4'd9, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[2]  = '{3'd6, 2'd0, 4'd0, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[3]  = '{3'd2, 2'd0, 4'd0, 4'd7,  4'd7,  1'b0, 4'd0, 4'd0};
        vecs[4]  = '{3'd2, 2'd1, 4'd0, 4'd0,  4'd15, 1'b1, 4'd0, 4'd0};
        vecs[5]  = '{3'd6, 2'd0, 4'd0, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[6]  = '{3'd1, 2'd0, 4'd3, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[7]  = '{3'd2, 2'd0, 4'd0, 4'd3,  4'd3,  1'b0, 4'd0, 4'd0};
        vecs[8]  = '{3'd1, 2'd1, 4'd5, 4'd3,  4'd3,  1'b0, 4'd0, 4'd0};
        vecs[9]  = '{3'd3, 2'd1, 4'd0, 4'd14, 4'd0,  1'b1, 4'd0, 4'd0};
        vecs[10] = '{3'd6, 2'd0, 4'd0, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[11] = '{3'd1, 2'd0, 4'd9, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0};
        vecs[12] = '{3'd2, 2'd0, 4'd0, 4'd9,  4'd9,  1'b0, 4'd0, 4'd0};
        vecs[13] = '{3'd4, 2'd0, 4'd0, 4'd2,  4'd15, 1'b1, 4'd0, 4'd0};
        vecs[14] = '{3'd7, 2'd0, 4'd0, 4'd2,  4'd15, 1'b1, 4'd2, 4'd15};
        vecs[15] = '{3'd6, 2'd0, 4'd0, 4'd0,  4'd0,  1'b0, 4'd2, 4'd15};
        vecs[16] = '{3'd2, 2'd0, 4'd0, 4'd9,  4'd9,  1'b0, 4'd2, 4'd15};
        vecs[17] = '{3'd5, 2'd0, 4'd0, 4'd4,  4'd4,  1'b0, 4'd2, 4'd15};
        vecs[18] = '{3'd4, 2'd0, 4'd0, 4'd8,  4'd8,  1'b0, 4'd2, 4'd15};
        vecs[19] = '{3'd4, 2'd0, 4'd0, 4'd0,  4'd15, 1'b1, 4'd2, 4'd15};
        vecs[20] = '{3'd5, 2'd0, 4'd0, 4'd0,  4'd7,  1'b1, 4'd2, 4'd15};
        vecs[21] = '{3'd0, 2'd0, 4'd0, 4'd0,  4'd7,  1'b1, 4'd2, 4'd15};
        vecs[22] = '{3'd7, 2'd0, 4'd0, 4'd0,  4'd7,  1'b1, 4'd0, 4'd7};
        vecs[23] = '{3'd3, 2'd0, 4'd0, 4'd7,  4'd0,  1'b1, 4'd0, 4'd7};
        vecs[24] = '{3'd2, 2'd1, 4'd0, 4'd12, 4'd5,  1'b1, 4'd0, 4'd7};

        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 4'd0);
        drive(1'b1, 1'b0, 3'd0, 2'd0, 4'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready",    int'(bus_a.op_ready), 1);
        check("rst_done",     int'(bus_a.done),     0);
        check("rst_acc",      int'(bus_a.acc),      0);
        check("rst_out",      int'(bus_a.out_data), 0);
        check("rst_overflow", int'(bus_a.overflow), 0);

        // Main vector table on the two-register instance.
        for (int v = 0; v < 25; v++) begin
            run_op(1'b0, vecs[v].code, vecs[v].sel, vecs[v].data, lat);
            check($sformatf("vec%0d_done_lat", v), lat, 3);
            check($sformatf("vec%0d_acc", v), int'(bus_a.acc),
                  SAT ? int'(vecs[v].acc_s) : int'(vecs[v].acc_w));
            check($sformatf("vec%0d_overflow", v), int'(bus_a.overflow), int'(vecs[v].ovf));
            check($sformatf("vec%0d_out", v), int'(bus_a.out_data),
                  SAT ? int'(vecs[v].out_s) : int'(vecs[v].out_w));
        end

        // Held op_valid: four ADDs of r0=1, one accept every third cycle.
        run_op(1'b0, 3'd6, 2'd0, 4'd0, lat);
        check("thr_clr_lat", lat, 3);
        run_op(1'b0, 3'd1, 2'd0, 4'd1, lat);
        check("thr_load_lat", lat, 3);
        drive(1'b0, 1'b1, 3'd2, 2'd0, 4'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("thr_ready_c%0d", k), int'(bus_a.op_ready), (k % 3 == 2) ? 1 : 0);
            check($sformatf("thr_done_c%0d", k),  int'(bus_a.done),     (k % 3 == 2) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 3'd2, 2'd0, 4'd0);
        check("thr_acc",      int'(bus_a.acc),      4);
        check("thr_overflow", int'(bus_a.overflow), 0);

        // Reset during EXEC of an ADD abandons it.
        drive(1'b0, 1'b1, 3'd2, 2'd0, 4'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd2, 2'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_done_in_rst", int'(bus_a.done), 0);
        check("abort_acc_in_rst",  int'(bus_a.acc),  0);
        @(negedge clk);
        check("abort_ready_after", int'(bus_a.op_ready), 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_no_done_c%0d", k), int'(bus_a.done), 0);
            check($sformatf("abort_acc_c%0d", k),     int'(bus_a.acc),  0);
            @(negedge clk);
        end
        run_op(1'b0, 3'd2, 2'd0, 4'd0, lat);
        check("abort_r0_cleared_acc", int'(bus_a.acc), 0);

        // Out-of-range index on the three-register instance.
        run_op(1'b1, 3'd1, 2'd0, 4'd2, lat);
        check("sel_load_r0_lat", lat, 3);
        run_op(1'b1, 3'd1, 2'd3, 4'd5, lat);
        check("sel3_load_lat", lat, 3);
        check("sel3_load_acc", acc_of(1'b1), 0);
        run_op(1'b1, 3'd2, 2'd3, 4'd0, lat);
        check("sel3_add_lat", lat, 3);
        check("sel3_add_acc", acc_of(1'b1), 0);
        run_op(1'b1, 3'd2, 2'd0, 4'd0, lat);
        check("sel0_add_acc", acc_of(1'b1), 2);
        run_op(1'b1, 3'd2, 2'd1, 4'd0, lat);
        check("sel1_add_acc", acc_of(1'b1), 2);
        run_op(1'b1, 3'd2, 2'd2, 4'd0, lat);
        check("sel2_add_acc", acc_of(1'b1), 2);
        check("b_overflow",   int'(bus_b.overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/accumulator_datapath.md
ACCUMULATOR_DATAPATH -- requirements
Module: accumulator_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of operand registers, accumulator and output register (>=2).
REQ-002 SHALL have parameter NUM_REGS, default 2: number of operand registers (>=1); SEL_W = max(1, clog2(NUM_REGS)).
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port op_valid, input, 1: an operation is presented.
REQ-006 SHALL have port op_ready, output, 1: block can accept an operation.
REQ-007 SHALL have port op_code, input, 3: operation select.
REQ-008 SHALL have port op_sel, input, SEL_W: operand register index.
REQ-009 SHALL have port op_data, input, WIDTH: load data.
REQ-010 SHALL have port acc, output, WIDTH: accumulator value.
REQ-011 SHALL have port out_data, output, WIDTH: output register value.
REQ-012 SHALL have port overflow, output, 1: sticky arithmetic overflow flag.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; op_ready=1 only in IDLE.
REQ-015 SHALL accept an operation in the cycle op_valid=1 and op_ready=1, capturing op_code, op_sel, op_data; FSM moves to EXEC.
REQ-016 SHALL in EXEC compute the result into an internal result register; in WB commit it and pulse done=1 for exactly one cycle (done two cycles after the accept edge), then return to IDLE.
REQ-017 SHALL ignore op_valid and input changes while in EXEC or WB; back-to-back throughput is one operation per 3 cycles.
REQ-018 SHALL decode op_code: 0 NOP; 1 LOAD reg[op_sel]<=op_data; 2 ADD acc<=acc+reg[op_sel]; 3 SUB acc<=acc-reg[op_sel]; 4 SHL acc<=acc<<1; 5 SHR acc<=acc>>1 logical; 6 CLR acc<=0 and overflow<=0; 7 OUT out_data<=acc.
REQ-019 SHALL flag overflow on ADD carry-out, on SUB borrow (unsigned reg>acc), on SHL when the shifted-out MSB is 1; flag set in WB, held until CLR or reset.
REQ-020 SHALL treat op_sel >= NUM_REGS as: operand reads 0, LOAD discarded; done still pulses.
REQ-021 SHALL keep acc, registers and out_data unchanged for ops that do not write them; NOP still pulses done.
REQ-022 SHALL use unsigned arithmetic, results truncated to WIDTH unless REQ-027 applies.

Reset
REQ-023 SHALL on reset=0 at a clock edge set FSM to IDLE, acc, out_data, all operand registers and overflow to 0, done to 0.
REQ-024 SHALL on reset during EXEC or WB abandon the operation: no commit, no done pulse.
REQ-025 SHALL drive op_ready=1 in the first cycle after reset is released.

Configuration
REQ-026 SHALL provide macro ACCUMULATOR_SATURATE_EN selecting overflow handling.
REQ-027 SHALL, with ACCUMULATOR_SATURATE_EN defined, clamp ADD and SHL overflow results to all-ones and SUB borrow results to 0; overflow flag still set.
REQ-028 SHALL, without ACCUMULATOR_SATURATE_EN, wrap results modulo 2^WIDTH.

Verification (WIDTH=4, NUM_REGS=2)
REQ-029 SHALL cover: LOAD r0=7, LOAD r1=9, CLR, ADD r0, ADD r1 -> acc=0 overflow=1 (wrap) / acc=15 overflow=1 (saturate).
REQ-030 SHALL cover: acc=3, r1=5, SUB r1 -> acc=14 overflow=1 (wrap) / acc=0 (saturate); then CLR -> acc=0 overflow=0.
REQ-031 SHALL cover: acc=4'b1001, SHL -> 4'b0010 overflow=1 (wrap); SHR from 4'b1001 -> 4'b0100 overflow unchanged; OUT -> out_data equals acc.
REQ-032 SHALL cover: op_valid held high with ADD r0 (r0=1) from acc=0 for 4 accepts -> done every 3rd cycle, acc=4, op_ready low 2 of every 3 cycles.
REQ-033 SHALL cover: reset=0 asserted in EXEC of an ADD -> no done, acc=0, op_ready=1 one cycle after release.
REQ-034 SHALL cover: NUM_REGS=3, op_sel=3 LOAD 5 then ADD sel 3 -> registers unchanged, acc unchanged, done pulses both times.
